rs_age_array: RTL and testbench
===============================

Name: rs_age_array

Overview:
- Parametrised reservation-station array: RS_ENTRIES slots, each holding one renamed instruction until both source operands are ready.
- Wakeup from CDB_PORTS parallel CDB broadcasts.
- Issues the oldest ready entry each cycle.
- Applies branch-mask resolve and squash to every slot.
- Sits between dispatch (rename/ROB allocation) and the FU issue mux. Generalises the single-entry RS to N entries, multi-CDB wakeup, age-ordered select and free-count flow control.

Parameters:
RS_ENTRIES, 8, number of slots (power of 2, >=2)
CDB_PORTS, 2, simultaneous CDB tag broadcasts
PRF_IDX_W, 6, physical register tag width
BR_MASK_W, 4, branch mask width (one-hot tags)
PAYLOAD_W, 48, opaque payload (IR, ROB idx, SQ position, fu_sel, ldl) carried unmodified
CNT_W, $clog2(RS_ENTRIES+1), free-count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
disp_vld_i  in  1  dispatch request
disp_opa_tag_i / disp_opb_tag_i  in  PRF_IDX_W each  source tags
disp_opa_rdy_i / disp_opb_rdy_i  in  1 each  source ready at rename
disp_dest_tag_i  in  PRF_IDX_W  destination tag
disp_br_mask_i  in  BR_MASK_W  branch dependence mask
disp_payload_i  in  PAYLOAD_W  opaque payload
cdb_vld_i  in  CDB_PORTS  per-port broadcast valid
cdb_tag_i  in  CDB_PORTS*PRF_IDX_W  per-port tag, port p in bits [p*PRF_IDX_W +: PRF_IDX_W]
iss_rdy_i  in  1  FU can accept an instruction this cycle
br_correct_i  in  1  branch resolved correct
br_recovery_i  in  1  branch mispredicted
br_tag_i  in  BR_MASK_W  one-hot tag of resolving branch
iss_vld_o  out  1  issue valid
iss_opa_tag_o / iss_opb_tag_o / iss_dest_tag_o  out  PRF_IDX_W each  issued tags
iss_br_mask_o  out  BR_MASK_W  issued mask, already cleared by same-cycle br_correct_i
iss_payload_o  out  PAYLOAD_W  issued payload
free_cnt_o  out  CNT_W  registered count of free slots
full_o  out  1  free_cnt_o == 0

Behaviour:
Reset:
- All slots invalid; rdy bits, masks and tags 0; age matrix 0.
- free_cnt_o = RS_ENTRIES; full_o = 0; iss_vld_o = 0; all iss_* outputs 0.

Wakeup:
- Slot operand rdy sets when any port p has cdb_vld_i[p] and cdb_tag_i[p] equal to the operand tag.
- The set is sticky until the slot is freed.
- Request is combinational: a slot requests issue in the same cycle that the CDB supplies its last missing operand (bypass). Both operands may wake on different ports in the same cycle.

Dispatch:
- Target is the lowest-index slot that was free at the start of the cycle.
- A slot issued in the same cycle is not reused until the next cycle.
- Stored rdy = disp_*_rdy_i OR a same-cycle CDB match.
- Stored mask = disp_br_mask_i & ~br_tag_i when br_correct_i.
- disp_vld_i with full_o = 1 is illegal: slots are unchanged, enforced by an assertion.
- An entry dispatched at cycle t is eligible to issue at t+1 at the earliest.

Age:
- RS_ENTRIES x RS_ENTRIES older matrix.
- On dispatch into slot k: row k is set to the current valid vector (all live slots are older than k) and column k is cleared.
- Freeing a slot needs no matrix update; its bit is masked by valid.

Select:
- req = valid & opa_rdy_eff & opb_rdy_eff & ~squash_now.
- Grant the slot with req set and no requesting slot older than it.
- iss_vld_o = iss_rdy_i & |req. Outputs are combinational from the granted slot.
- The granted slot is freed at the next edge.

Branch resolve:
- br_correct_i: clear br_tag_i in every slot mask and in iss_br_mask_o in the same cycle.
- br_recovery_i: squash_now = valid & (mask & br_tag_i) != 0. Those slots are freed at the next edge and masked from select in the current cycle.
- An incoming dispatch whose mask hits br_tag_i is dropped.
- br_correct_i and br_recovery_i are never both asserted (assertion).

Free count:
- free_cnt_o(next) = free_cnt_o + issued + squashed − dispatched_kept.
- Registered; full_o is derived from it.

Simultaneous events:
- Issue and squash of the same slot: squash wins, iss_vld_o = 0 for that slot, another ready slot may be granted.
- Dispatch and recovery in the same cycle: the dispatch is kept if its mask is clear of br_tag_i.

Reset mid-operation: all state returns to reset values at the next edge; no issue occurs in the reset cycle.

Decomposition:
- rs_pkg: rs_entry_t struct (valid, opa/opb tag + rdy, dest tag, br_mask, payload) and parameter defaults.
- Sub-module rs_age_select: purely combinational. Takes req and the older matrix; produces a one-hot grant and a grant index.
- The top module holds slot storage, wakeup, free-slot priority encoder and counters.

Test Plan:
1. Reset, then dispatch 8 entries, each with both rdy=0, opa tag=10+i, opb tag=20+i; iss_rdy_i=1 -> full_o=1 and free_cnt_o=0 after the 8th edge; iss_vld_o stays 0.
2. With scenario 1's entries held, broadcast on the same cycle cdb_tag_i = {port1=25, port0=15}, then on the next cycle {port1=23, port0=13} -> entry 5 issues in the first cycle (iss_dest_tag_o = entry 5's) and entry 3 in the second; each is issued in its own broadcast cycle with no extra latency.
3. Age: dispatch A (slot0), B, C, issue B, dispatch D (slot1), make A and D both ready in the same cycle -> A issues first, D next cycle.
4. Entries with masks 4'b0010, 4'b0011, 4'b0100; br_recovery_i=1, br_tag_i=4'b0010 -> first two freed next cycle, free_cnt_o += 2, third retained; a ready squashed slot never appears on iss_vld_o.
5. br_correct_i=1, br_tag_i=4'b0001 while a ready entry with mask 4'b0101 issues -> iss_br_mask_o=4'b0100; remaining entries have bit0 cleared.
6. Dispatch with opa tag 7 while CDB port1 broadcasts tag 7 and opb already ready -> entry issues the next cycle without further broadcast; rst asserted mid-stream -> next cycle free_cnt_o=8 and iss_vld_o=0.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared defaults and the slot record for the age-ordered reservation station.
package rs_pkg;

  localparam int RS_ENTRIES_DEF = 8;
  localparam int CDB_PORTS_DEF  = 2;
  localparam int PRF_IDX_W_DEF  = 6;
  localparam int BR_MASK_W_DEF  = 4;
  localparam int PAYLOAD_W_DEF  = 48;

  // One reservation-station slot at the default widths.
  typedef struct packed {
    logic                     valid;
    logic [PRF_IDX_W_DEF-1:0] opa_tag;
    logic                     opa_rdy;
    logic [PRF_IDX_W_DEF-1:0] opb_tag;
    logic                     opb_rdy;
    logic [PRF_IDX_W_DEF-1:0] dest_tag;
    logic [BR_MASK_W_DEF-1:0] br_mask;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first select: grants the requesting slot that has no older requester.
module rs_age_select #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]   req,
  input  logic [N*N-1:0] older_flat,
  output logic [N-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic           grant_any
);

  // Row k of the matrix marks every slot that is older than slot k.
  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = req[gi] & ~(|(req & older_flat[gi*N +: N]));
  end

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) grant_idx = IDX_W'(k);
    end
  end

  assign grant_any = |grant;

endmodule

// File: rtl/rs_age_array.sv
// N-slot reservation station with multi-port CDB wakeup, age-ordered issue,
// branch-mask resolve/squash and a registered free-slot count.
module rs_age_array
  import rs_pkg::*;
#(
  parameter int RS_ENTRIES = RS_ENTRIES_DEF,
  parameter int CDB_PORTS  = CDB_PORTS_DEF,
  parameter int PRF_IDX_W  = PRF_IDX_W_DEF,
  parameter int BR_MASK_W  = BR_MASK_W_DEF,
  parameter int PAYLOAD_W  = PAYLOAD_W_DEF,
  parameter int CNT_W      = $clog2(RS_ENTRIES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           disp_vld_i,
  input  logic [PRF_IDX_W-1:0]           disp_opa_tag_i,
  input  logic [PRF_IDX_W-1:0]           disp_opb_tag_i,
  input  logic                           disp_opa_rdy_i,
  input  logic                           disp_opb_rdy_i,
  input  logic [PRF_IDX_W-1:0]           disp_dest_tag_i,
  input  logic [BR_MASK_W-1:0]           disp_br_mask_i,
  input  logic [PAYLOAD_W-1:0]           disp_payload_i,
  input  logic [CDB_PORTS-1:0]           cdb_vld_i,
  input  logic [CDB_PORTS*PRF_IDX_W-1:0] cdb_tag_i,
  input  logic                           iss_rdy_i,
  input  logic                           br_correct_i,
  input  logic                           br_recovery_i,
  input  logic [BR_MASK_W-1:0]           br_tag_i,
  output logic                           iss_vld_o,
  output logic [PRF_IDX_W-1:0]           iss_opa_tag_o,
  output logic [PRF_IDX_W-1:0]           iss_opb_tag_o,
  output logic [PRF_IDX_W-1:0]           iss_dest_tag_o,
  output logic [BR_MASK_W-1:0]           iss_br_mask_o,
  output logic [PAYLOAD_W-1:0]           iss_payload_o,
  output logic [CNT_W-1:0]               free_cnt_o,
  output logic                           full_o
);

  localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  logic [RS_ENTRIES-1:0] valid_reg, valid_next;
  logic [RS_ENTRIES-1:0] opa_rdy_reg, opa_rdy_next;
  logic [RS_ENTRIES-1:0] opb_rdy_reg, opb_rdy_next;
  logic [PRF_IDX_W-1:0]  opa_tag_reg [RS_ENTRIES];
  logic [PRF_IDX_W-1:0]  opa_tag_next [RS_ENTRIES];
  logic [PRF_IDX_W-1:0]  opb_tag_reg [RS_ENTRIES];
  logic [PRF_IDX_W-1:0]  opb_tag_next [RS_ENTRIES];
  logic [PRF_IDX_W-1:0]  dest_tag_reg [RS_ENTRIES];
  logic [PRF_IDX_W-1:0]  dest_tag_next [RS_ENTRIES];
  logic [BR_MASK_W-1:0]  mask_reg [RS_ENTRIES];
  logic [BR_MASK_W-1:0]  mask_next [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  payload_reg [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  payload_next [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] older_reg [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] older_next [RS_ENTRIES];
  logic [CNT_W-1:0]      free_cnt_reg, free_cnt_next;

  logic [RS_ENTRIES-1:0] opa_hit, opb_hit, opa_rdy_eff, opb_rdy_eff;
  logic [RS_ENTRIES-1:0] squash_now, req, grant, clear_vec;
  logic [RS_ENTRIES*RS_ENTRIES-1:0] older_flat;
  logic [CDB_PORTS-1:0]  disp_opa_match, disp_opb_match;
  logic [IDX_W-1:0]      grant_idx, disp_idx;
  logic                  grant_any, free_found, issue_fire, disp_drop, disp_keep;
  logic [BR_MASK_W-1:0]  br_clear;
  logic [CNT_W-1:0]      squash_cnt;

  // Per-slot wakeup, squash and request; a CDB match counts as ready this cycle.
  for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_slot
    logic [CDB_PORTS-1:0] a_match, b_match;
    for (genvar gp = 0; gp < CDB_PORTS; gp++) begin : g_port
      assign a_match[gp] = cdb_vld_i[gp] &&
                           (cdb_tag_i[gp*PRF_IDX_W +: PRF_IDX_W] == opa_tag_reg[gi]);
      assign b_match[gp] = cdb_vld_i[gp] &&
                           (cdb_tag_i[gp*PRF_IDX_W +: PRF_IDX_W] == opb_tag_reg[gi]);
    end
    assign opa_hit[gi]     = valid_reg[gi] & (|a_match);
    assign opb_hit[gi]     = valid_reg[gi] & (|b_match);
    assign opa_rdy_eff[gi] = opa_rdy_reg[gi] | opa_hit[gi];
    assign opb_rdy_eff[gi] = opb_rdy_reg[gi] | opb_hit[gi];
    assign squash_now[gi]  = br_recovery_i & valid_reg[gi] & (|(mask_reg[gi] & br_tag_i));
    assign req[gi]         = valid_reg[gi] & opa_rdy_eff[gi] & opb_rdy_eff[gi] & ~squash_now[gi];
    assign older_flat[gi*RS_ENTRIES +: RS_ENTRIES] = older_reg[gi];
  end

  for (genvar gi = 0; gi < CDB_PORTS; gi++) begin : g_disp_match
    assign disp_opa_match[gi] = cdb_vld_i[gi] &&
                                (cdb_tag_i[gi*PRF_IDX_W +: PRF_IDX_W] == disp_opa_tag_i);
    assign disp_opb_match[gi] = cdb_vld_i[gi] &&
                                (cdb_tag_i[gi*PRF_IDX_W +: PRF_IDX_W] == disp_opb_tag_i);
  end

  rs_age_select #(
    .N     (RS_ENTRIES),
    .IDX_W (IDX_W)
  ) u_select (
    .req        (req),
    .older_flat (older_flat),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Lowest-index slot free at the start of the cycle; same-cycle frees wait a cycle.
  always_comb begin
    disp_idx   = '0;
    free_found = 1'b0;
    for (int k = 0; k < RS_ENTRIES; k++) begin
      if (!free_found && !valid_reg[k]) begin
        disp_idx   = IDX_W'(k);
        free_found = 1'b1;
      end
    end
  end

  assign issue_fire = iss_rdy_i & grant_any & ~rst;
  assign br_clear   = br_correct_i ? br_tag_i : '0;
  assign disp_drop  = br_recovery_i & (|(disp_br_mask_i & br_tag_i));
  assign disp_keep  = disp_vld_i & ~full_o & free_found & ~disp_drop;
  assign clear_vec  = (grant & {RS_ENTRIES{issue_fire}}) | squash_now;

  always_comb begin
    valid_next   = valid_reg & ~clear_vec;
    opa_rdy_next = (opa_rdy_reg | opa_hit) & ~clear_vec;
    opb_rdy_next = (opb_rdy_reg | opb_hit) & ~clear_vec;
    for (int k = 0; k < RS_ENTRIES; k++) begin
      opa_tag_next[k]  = opa_tag_reg[k];
      opb_tag_next[k]  = opb_tag_reg[k];
      dest_tag_next[k] = dest_tag_reg[k];
      mask_next[k]     = mask_reg[k] & ~br_clear;
      payload_next[k]  = payload_reg[k];
      older_next[k]    = older_reg[k];
    end
    if (disp_keep) begin
      valid_next[disp_idx]    = 1'b1;
      opa_tag_next[disp_idx]  = disp_opa_tag_i;
      opb_tag_next[disp_idx]  = disp_opb_tag_i;
      opa_rdy_next[disp_idx]  = disp_opa_rdy_i | (|disp_opa_match);
      opb_rdy_next[disp_idx]  = disp_opb_rdy_i | (|disp_opb_match);
      dest_tag_next[disp_idx] = disp_dest_tag_i;
      mask_next[disp_idx]     = disp_br_mask_i & ~br_clear;
      payload_next[disp_idx]  = disp_payload_i;
      // New entry is younger than every live slot and older than none.
      for (int k = 0; k < RS_ENTRIES; k++) begin
        older_next[k][disp_idx] = 1'b0;
      end
      older_next[disp_idx] = valid_reg;
    end
  end

  always_comb begin
    squash_cnt = '0;
    for (int k = 0; k < RS_ENTRIES; k++) begin
      squash_cnt = squash_cnt + CNT_W'(squash_now[k]);
    end
    free_cnt_next = free_cnt_reg + CNT_W'(issue_fire) + squash_cnt - CNT_W'(disp_keep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      opa_rdy_reg  <= '0;
      opb_rdy_reg  <= '0;
      free_cnt_reg <= CNT_W'(RS_ENTRIES);
      for (int k = 0; k < RS_ENTRIES; k++) begin
        opa_tag_reg[k]  <= '0;
        opb_tag_reg[k]  <= '0;
        dest_tag_reg[k] <= '0;
        mask_reg[k]     <= '0;
        payload_reg[k]  <= '0;
        older_reg[k]    <= '0;
      end
    end else begin
      valid_reg    <= valid_next;
      opa_rdy_reg  <= opa_rdy_next;
      opb_rdy_reg  <= opb_rdy_next;
      free_cnt_reg <= free_cnt_next;
      for (int k = 0; k < RS_ENTRIES; k++) begin
        opa_tag_reg[k]  <= opa_tag_next[k];
        opb_tag_reg[k]  <= opb_tag_next[k];
        dest_tag_reg[k] <= dest_tag_next[k];
        mask_reg[k]     <= mask_next[k];
        payload_reg[k]  <= payload_next[k];
        older_reg[k]    <= older_next[k];
      end
    end
  end

  assign iss_vld_o      = issue_fire;
  assign iss_opa_tag_o  = issue_fire ? opa_tag_reg[grant_idx]  : '0;
  assign iss_opb_tag_o  = issue_fire ? opb_tag_reg[grant_idx]  : '0;
  assign iss_dest_tag_o = issue_fire ? dest_tag_reg[grant_idx] : '0;
  assign iss_br_mask_o  = issue_fire ? (mask_reg[grant_idx] & ~br_clear) : '0;
  assign iss_payload_o  = issue_fire ? payload_reg[grant_idx]  : '0;
  assign free_cnt_o     = free_cnt_reg;
  assign full_o         = (free_cnt_reg == '0);

  a_no_disp_when_full : assert property (@(posedge clk) disable iff (rst)
    !(disp_vld_i && full_o));
  a_br_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(br_correct_i && br_recovery_i));

endmodule

// File: tb/tb_rs_age_array.sv
// Directed scenarios plus randomized traffic checked against an age-stamp model.
module tb_rs_age_array;
  import rs_pkg::*;

  localparam int N  = 8;
  localparam int P  = 2;
  localparam int TW = 6;
  localparam int MW = 4;
  localparam int PW = 48;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_vld, disp_opa_rdy, disp_opb_rdy;
  logic [TW-1:0] disp_opa_tag, disp_opb_tag, disp_dest_tag;
  logic [MW-1:0] disp_br_mask;
  logic [PW-1:0] disp_payload;
  logic [P-1:0]  cdb_vld;
  logic [P*TW-1:0] cdb_tag;
  logic          iss_rdy, br_correct, br_recovery;
  logic [MW-1:0] br_tag;
  logic          iss_vld, full;
  logic [TW-1:0] iss_opa_tag, iss_opb_tag, iss_dest_tag;
  logic [MW-1:0] iss_br_mask;
  logic [PW-1:0] iss_payload;
  logic [CW-1:0] free_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rs_age_array dut (
    .clk(clk), .rst(rst),
    .disp_vld_i(disp_vld), .disp_opa_tag_i(disp_opa_tag), .disp_opb_tag_i(disp_opb_tag),
    .disp_opa_rdy_i(disp_opa_rdy), .disp_opb_rdy_i(disp_opb_rdy),
    .disp_dest_tag_i(disp_dest_tag), .disp_br_mask_i(disp_br_mask),
    .disp_payload_i(disp_payload), .cdb_vld_i(cdb_vld), .cdb_tag_i(cdb_tag),
    .iss_rdy_i(iss_rdy), .br_correct_i(br_correct), .br_recovery_i(br_recovery),
    .br_tag_i(br_tag), .iss_vld_o(iss_vld), .iss_opa_tag_o(iss_opa_tag),
    .iss_opb_tag_o(iss_opb_tag), .iss_dest_tag_o(iss_dest_tag),
    .iss_br_mask_o(iss_br_mask), .iss_payload_o(iss_payload),
    .free_cnt_o(free_cnt), .full_o(full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_vld = 1'b0; disp_opa_tag = '0; disp_opb_tag = '0; disp_opa_rdy = 1'b0;
    disp_opb_rdy = 1'b0; disp_dest_tag = '0; disp_br_mask = '0; disp_payload = '0;
    cdb_vld = '0; cdb_tag = '0; iss_rdy = 1'b0;
    br_correct = 1'b0; br_recovery = 1'b0; br_tag = '0;
  endtask

  task automatic disp(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic ar,
                      input logic br, input logic [TW-1:0] d, input logic [MW-1:0] m);
    disp_vld = 1'b1; disp_opa_tag = a; disp_opb_tag = b; disp_opa_rdy = ar;
    disp_opb_rdy = br; disp_dest_tag = d; disp_br_mask = m;
    disp_payload = {36'hABCDE1234, 6'd0, d};
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (free_cnt !== 4'd8) begin n_bad++; $display("FAIL reset_free_cnt act=%0d exp=8", free_cnt); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full act=%0b exp=0", full); end
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL reset_iss_vld act=%0b exp=0", iss_vld); end
    n_cmp++; if (iss_dest_tag !== 6'd0) begin n_bad++; $display("FAIL reset_iss_dest act=%0d exp=0", iss_dest_tag); end
    n_cmp++; if (iss_payload !== 48'd0) begin n_bad++; $display("FAIL reset_iss_payload act=%h exp=0", iss_payload); end
    $display("test_reset done");
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      disp(6'(10 + i), 6'(20 + i), 1'b0, 1'b0, 6'(30 + i), 4'b0000);
      iss_rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL fill_iss_vld[%0d] act=%0b exp=0", i, iss_vld); end
      n_cmp++; if (free_cnt !== CW'(N - i)) begin n_bad++; $display("FAIL fill_free_cnt[%0d] act=%0d exp=%0d", i, free_cnt, N - i); end
      $display("fill dispatch %0d free_cnt=%0d", i, free_cnt);
      tick();
    end
    idle();
    iss_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full act=%0b exp=1", full); end
    n_cmp++; if (free_cnt !== 4'd0) begin n_bad++; $display("FAIL fill_free_zero act=%0d exp=0", free_cnt); end
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL fill_idle_iss act=%0b exp=0", iss_vld); end
    tick();
  endtask

  task automatic test_wakeup();
    iss_rdy = 1'b1;
    cdb_vld = 2'b11;
    cdb_tag = {6'd25, 6'd15};
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1) begin n_bad++; $display("FAIL wake1_vld act=%0b exp=1", iss_vld); end
    n_cmp++; if (iss_dest_tag !== 6'd35) begin n_bad++; $display("FAIL wake1_dest act=%0d exp=35", iss_dest_tag); end
    n_cmp++; if (iss_opb_tag !== 6'd25) begin n_bad++; $display("FAIL wake1_opb act=%0d exp=25", iss_opb_tag); end
    $display("wakeup cycle 1 iss_vld=%0b dest=%0d", iss_vld, iss_dest_tag);
    tick();
    cdb_tag = {6'd23, 6'd13};
    @(negedge clk);
    n_cmp++; if (iss_dest_tag !== 6'd33 || iss_vld !== 1'b1) begin n_bad++; $display("FAIL wake2_dest act=%0b/%0d exp=1/33", iss_vld, iss_dest_tag); end
    n_cmp++; if (free_cnt !== 4'd1) begin n_bad++; $display("FAIL wake2_free act=%0d exp=1", free_cnt); end
    $display("wakeup cycle 2 iss_vld=%0b dest=%0d", iss_vld, iss_dest_tag);
    tick();
    cdb_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (free_cnt !== 4'd2) begin n_bad++; $display("FAIL wake3_free act=%0d exp=2", free_cnt); end
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL wake3_vld act=%0b exp=0", iss_vld); end
    tick();
  endtask

  task automatic test_age();
    do_reset();
    disp(6'd1, 6'd2, 1'b0, 1'b1, 6'd40, 4'b0000); tick();
    disp(6'd30, 6'd31, 1'b1, 1'b1, 6'd41, 4'b0000); tick();
    disp(6'd3, 6'd4, 1'b0, 1'b0, 6'd42, 4'b0000); tick();
    idle(); iss_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_dest_tag !== 6'd41) begin n_bad++; $display("FAIL age_b act=%0b/%0d exp=1/41", iss_vld, iss_dest_tag); end
    tick();
    disp(6'd5, 6'd6, 1'b0, 1'b1, 6'd43, 4'b0000);
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL age_d_disp act=%0b exp=0", iss_vld); end
    tick();
    idle(); iss_rdy = 1'b1; cdb_vld = 2'b11; cdb_tag = {6'd5, 6'd1};
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_dest_tag !== 6'd40) begin n_bad++; $display("FAIL age_a_first act=%0b/%0d exp=1/40", iss_vld, iss_dest_tag); end
    $display("age cycle A dest=%0d", iss_dest_tag);
    tick();
    cdb_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_dest_tag !== 6'd43) begin n_bad++; $display("FAIL age_d_next act=%0b/%0d exp=1/43", iss_vld, iss_dest_tag); end
    $display("age cycle D dest=%0d", iss_dest_tag);
    tick();
    @(negedge clk);
    n_cmp++; if (free_cnt !== 4'd7) begin n_bad++; $display("FAIL age_free act=%0d exp=7", free_cnt); end
    tick();
  endtask

  task automatic test_squash();
    do_reset();
    disp(6'd1, 6'd2, 1'b1, 1'b1, 6'd50, 4'b0010); tick();
    disp(6'd3, 6'd4, 1'b0, 1'b0, 6'd51, 4'b0011); tick();
    disp(6'd8, 6'd9, 1'b0, 1'b0, 6'd52, 4'b0100); tick();
    disp(6'd5, 6'd6, 1'b1, 1'b1, 6'd53, 4'b0100); tick();
    idle();
    @(negedge clk);
    n_cmp++; if (free_cnt !== 4'd4) begin n_bad++; $display("FAIL sq_pre_free act=%0d exp=4", free_cnt); end
    tick();
    iss_rdy = 1'b1; br_recovery = 1'b1; br_tag = 4'b0010;
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_dest_tag !== 6'd53) begin n_bad++; $display("FAIL sq_grant act=%0b/%0d exp=1/53", iss_vld, iss_dest_tag); end
    $display("squash cycle iss_vld=%0b dest=%0d", iss_vld, iss_dest_tag);
    tick();
    br_recovery = 1'b0; br_tag = 4'b0000;
    @(negedge clk);
    n_cmp++; if (free_cnt !== 4'd7) begin n_bad++; $display("FAIL sq_post_free act=%0d exp=7", free_cnt); end
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL sq_post_vld act=%0b exp=0", iss_vld); end
    tick();
    cdb_vld = 2'b11; cdb_tag = {6'd9, 6'd8};
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_dest_tag !== 6'd52) begin n_bad++; $display("FAIL sq_kept act=%0b/%0d exp=1/52", iss_vld, iss_dest_tag); end
    tick();
    cdb_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (free_cnt !== 4'd8) begin n_bad++; $display("FAIL sq_empty act=%0d exp=8", free_cnt); end
    tick();
  endtask

  task automatic test_correct();
    do_reset();
    disp(6'd1, 6'd2, 1'b1, 1'b1, 6'd60, 4'b0101); tick();
    disp(6'd11, 6'd12, 1'b0, 1'b0, 6'd61, 4'b0011); tick();
    idle(); iss_rdy = 1'b1; br_correct = 1'b1; br_tag = 4'b0001;
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_dest_tag !== 6'd60) begin n_bad++; $display("FAIL corr_vld act=%0b/%0d exp=1/60", iss_vld, iss_dest_tag); end
    n_cmp++; if (iss_br_mask !== 4'b0100) begin n_bad++; $display("FAIL corr_mask act=%b exp=0100", iss_br_mask); end
    $display("correct cycle mask=%b", iss_br_mask);
    tick();
    br_correct = 1'b0; br_tag = 4'b0000; cdb_vld = 2'b11; cdb_tag = {6'd12, 6'd11};
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_br_mask !== 4'b0010) begin n_bad++; $display("FAIL corr_rest act=%0b/%b exp=1/0010", iss_vld, iss_br_mask); end
    tick();
  endtask

  task automatic test_bypass_reset();
    do_reset();
    iss_rdy = 1'b1;
    disp(6'd7, 6'd3, 1'b0, 1'b1, 6'd70, 4'b0000);
    cdb_vld = 2'b10; cdb_tag = {6'd7, 6'd0};
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL byp_same act=%0b exp=0", iss_vld); end
    tick();
    idle(); iss_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b1 || iss_dest_tag !== 6'd70) begin n_bad++; $display("FAIL byp_next act=%0b/%0d exp=1/70", iss_vld, iss_dest_tag); end
    $display("bypass issue dest=%0d", iss_dest_tag);
    tick();
    iss_rdy = 1'b0;
    disp(6'd1, 6'd2, 1'b1, 1'b1, 6'd71, 4'b0000); tick();
    idle(); rst = 1'b1; iss_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL rst_cycle_vld act=%0b exp=0", iss_vld); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (free_cnt !== 4'd8) begin n_bad++; $display("FAIL rst_free act=%0d exp=8", free_cnt); end
    n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL rst_vld act=%0b exp=0", iss_vld); end
    tick();
  endtask

  // Reference model: unordered entries stamped with a dispatch sequence number.
  rs_entry_t m_ent[N];
  int        m_age[N];
  int        m_seq;

  function automatic bit cdb_hit(input logic [TW-1:0] t);
    for (int p = 0; p < P; p++) begin
      if (cdb_vld[p] && cdb_tag[p*TW +: TW] == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic test_random();
    int m_free, best, slot;
    bit exp_vld;
    logic [MW-1:0] clr;
    do_reset();
    m_seq = 0;
    for (int k = 0; k < N; k++) begin
      m_ent[k] = '0;
      m_age[k] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      m_free = 0;
      for (int k = 0; k < N; k++) if (!m_ent[k].valid) m_free++;
      idle();
      iss_rdy = ($urandom_range(0, 3) != 0);
      if (m_free > 0 && full !== 1'b1 && $urandom_range(0, 1) == 1) begin
        disp(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             6'($urandom_range(0, 63)),
             4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        disp_payload = PW'({$urandom(), $urandom()});
      end
      cdb_vld = 2'($urandom_range(0, 3));
      cdb_tag = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      case ($urandom_range(0, 7))
        0: br_recovery = 1'b1;
        1: br_correct = 1'b1;
        default: ;
      endcase
      br_tag = 4'b0001 << $urandom_range(0, 3);
      clr = br_correct ? br_tag : 4'b0000;

      best = -1;
      for (int k = 0; k < N; k++) begin
        if (m_ent[k].valid && !(br_recovery && (m_ent[k].br_mask & br_tag) != 0) &&
            (m_ent[k].opa_rdy || cdb_hit(m_ent[k].opa_tag)) &&
            (m_ent[k].opb_rdy || cdb_hit(m_ent[k].opb_tag)) &&
            (best < 0 || m_age[k] < m_age[best]))
          best = k;
      end
      exp_vld = iss_rdy && (best >= 0);

      @(negedge clk);
      n_cmp++; if (iss_vld !== exp_vld) begin n_bad++; $display("FAIL rnd_vld[%0d] act=%0b exp=%0b", cyc, iss_vld, exp_vld); end
      n_cmp++; if (free_cnt !== CW'(m_free)) begin n_bad++; $display("FAIL rnd_free[%0d] act=%0d exp=%0d", cyc, free_cnt, m_free); end
      n_cmp++; if (full !== (m_free == 0)) begin n_bad++; $display("FAIL rnd_full[%0d] act=%0b exp=%0b", cyc, full, m_free == 0); end
      if (exp_vld) begin
        n_cmp++; if (iss_dest_tag !== m_ent[best].dest_tag || iss_opa_tag !== m_ent[best].opa_tag ||
                     iss_opb_tag !== m_ent[best].opb_tag) begin
          n_bad++; $display("FAIL rnd_tags[%0d] act=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc, iss_dest_tag,
                            iss_opa_tag, iss_opb_tag, m_ent[best].dest_tag, m_ent[best].opa_tag, m_ent[best].opb_tag);
        end
        n_cmp++; if (iss_payload !== m_ent[best].payload) begin n_bad++; $display("FAIL rnd_payload[%0d] act=%h exp=%h", cyc, iss_payload, m_ent[best].payload); end
        n_cmp++; if (iss_br_mask !== (m_ent[best].br_mask & ~clr)) begin n_bad++; $display("FAIL rnd_mask[%0d] act=%b exp=%b", cyc, iss_br_mask, m_ent[best].br_mask & ~clr); end
      end else begin
        n_cmp++; if (iss_dest_tag !== 6'd0) begin n_bad++; $display("FAIL rnd_idle_dest[%0d] act=%0d exp=0", cyc, iss_dest_tag); end
      end
      $display("rnd %0d disp=%0b iss=%0b dest=%0d free=%0d", cyc, disp_vld, iss_vld, iss_dest_tag, free_cnt);

      if (exp_vld) m_ent[best].valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_ent[k].valid) begin
          if (br_recovery && (m_ent[k].br_mask & br_tag) != 0) begin
            m_ent[k].valid = 1'b0;
          end else begin
            m_ent[k].opa_rdy = m_ent[k].opa_rdy | cdb_hit(m_ent[k].opa_tag);
            m_ent[k].opb_rdy = m_ent[k].opb_rdy | cdb_hit(m_ent[k].opb_tag);
            m_ent[k].br_mask = m_ent[k].br_mask & ~clr;
          end
        end
      end
      if (disp_vld && !(br_recovery && (disp_br_mask & br_tag) != 0)) begin
        slot = -1;
        for (int k = 0; k < N; k++) if (slot < 0 && !m_ent[k].valid) slot = k;
        if (slot >= 0) begin
          m_ent[slot].valid    = 1'b1;
          m_ent[slot].opa_tag  = disp_opa_tag;
          m_ent[slot].opb_tag  = disp_opb_tag;
          m_ent[slot].opa_rdy  = disp_opa_rdy | cdb_hit(disp_opa_tag);
          m_ent[slot].opb_rdy  = disp_opb_rdy | cdb_hit(disp_opb_tag);
          m_ent[slot].dest_tag = disp_dest_tag;
          m_ent[slot].br_mask  = disp_br_mask & ~clr;
          m_ent[slot].payload  = disp_payload;
          m_age[slot] = m_seq;
          m_seq++;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_fill();
    test_wakeup();
    test_age();
    test_squash();
    test_correct();
    test_bypass_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
